// File: rtl/adder_1.sv
// Pipelined unsigned adder: sout = a + b (WIDTH+1 bits, carry-out in the top bit).
// The operand is split into SLICE-bit slices, one slice per pipeline stage; each
// slice is a two-level carry-lookahead adder built from 4-bit CLA groups.
// Each stage carries one packed register laid out as
//     {remaining b bits, remaining a bits, slice carry-out, sum bits done so far}
// so that later stages only hold the operand bits they still need.
// At least two stages are assumed (WIDTH >= 2*SLICE), and SLICE must be a multiple of 4.
module adder_1 #(
    parameter int WIDTH = 64,
    parameter int SLICE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH:0]   sout
);

    localparam int STAGES = WIDTH / SLICE;
    localparam int GROUPS = SLICE / 4;

    // 4-bit CLA group: returns {group generate, group propagate, sum[3:0]}.
    // Bit carries are flattened lookahead terms rather than a ripple.
    function automatic logic [5:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic cin);
        logic [3:0] g;
        logic [3:0] p;
        logic [3:0] c;
        logic       gg;
        logic       pp;
        g    = x & y;
        p    = x ^ y;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        pp   = &p;
        return {gg, pp, p ^ c};
    endfunction

    // One SLICE-bit adder: group G/P do not depend on the carry-in,
    // group carries are then resolved from G/P, and each group forms its sum
    // from its own resolved carry-in. Returns {carry_out, sum}.
    function automatic logic [SLICE:0] cla_slice(input logic [SLICE-1:0] x, input logic [SLICE-1:0] y,
                                                 input logic cin);
        logic [GROUPS:0]   gc;
        logic [GROUPS-1:0] gg;
        logic [GROUPS-1:0] pp;
        logic [5:0]        r;
        logic [SLICE-1:0]  s;
        gc = '0;
        gg = '0;
        pp = '0;
        r  = '0;
        s  = '0;
        for (int j = 0; j < GROUPS; j++) begin
            r     = cla4(x[4*j +: 4], y[4*j +: 4], 1'b0);
            gg[j] = r[5];
            pp[j] = r[4];
        end
        gc[0] = cin;
        for (int j = 0; j < GROUPS; j++) begin
            gc[j+1] = gg[j] | (pp[j] & gc[j]);
        end
        for (int j = 0; j < GROUPS; j++) begin
            r            = cla4(x[4*j +: 4], y[4*j +: 4], gc[j]);
            s[4*j +: 4]  = r[3:0];
        end
        return {gc[GROUPS], s};
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : stage
            localparam int LO  = gi * SLICE;            // first bit added by this stage
            localparam int HI  = LO + SLICE;            // sum bits complete after this stage
            localparam int REM = WIDTH - HI;            // operand bits still to be added
            localparam int DW  = HI + 1 + 2 * REM;      // packed stage register width

            logic             valid_reg;
            logic [DW-1:0]    data_reg;
            logic             prev_valid;
            logic [SLICE-1:0] op_a;
            logic [SLICE-1:0] op_b;
            logic             cin;
            logic [SLICE:0]   slice_sum;
            logic [DW-1:0]    data_next;

            if (gi == 0) begin : src
                // First slice adds straight from the ports with no carry-in.
                assign prev_valid = in_valid;
                assign op_a       = a[SLICE-1:0];
                assign op_b       = b[SLICE-1:0];
                assign cin        = 1'b0;
                assign data_next  = {b[WIDTH-1:SLICE], a[WIDTH-1:SLICE], slice_sum};
            end else begin : src
                localparam int PW = LO + 1 + 2 * (WIDTH - LO);
                logic [PW-1:0] prev;
                assign prev       = stage[gi-1].data_reg;
                assign prev_valid = stage[gi-1].valid_reg;
                assign op_a       = prev[LO+1 +: SLICE];
                assign op_b       = prev[LO+1+(WIDTH-LO) +: SLICE];
                assign cin        = prev[LO];
                if (REM > 0) begin : fwd
                    assign data_next = {prev[PW-1 -: REM], prev[LO+1+SLICE +: REM], slice_sum, prev[LO-1:0]};
                end else begin : last
                    assign data_next = {slice_sum, prev[LO-1:0]};
                end
            end

            assign slice_sum = cla_slice(op_a, op_b, cin);

            // Stage register: valid always advances, data loads only for a valid operation.
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg <= 1'b0;
                    data_reg  <= '0;
                end else begin
                    valid_reg <= prev_valid;
                    if (prev_valid) begin
                        data_reg <= data_next;
                    end
                end
            end
        end
    endgenerate

    assign out_valid = stage[STAGES-1].valid_reg;
    assign sout      = stage[STAGES-1].data_reg;

endmodule

// File: tb/tb_adder_1.sv
// Directed and randomised checks for the pipelined adder adder_1.
module tb_adder_1;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [63:0] a;
    logic [63:0] b;
    logic        out_valid;
    logic [64:0] sout;

    int n_checks = 0;
    int n_fail   = 0;
    bit verbose  = 1'b1;

    // Reference pipeline state for the random run
    logic        m_v [4];
    logic [64:0] m_s [4];

    always #5 clk = ~clk;

    adder_1 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .sout      (sout)
    );

    task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else if (verbose) begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single operation followed by idle cycles with X operands: checks latency,
    // the single out_valid pulse and that sout holds afterwards.
    task automatic single_op(input string tag, input logic [63:0] x, input logic [63:0] y,
                             input logic [64:0] exp);
        a        = x;
        b        = y;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a        = 'x;
        b        = 'x;
        for (int i = 0; i < 3; i++) begin
            check({tag, " early valid"}, {64'd0, out_valid}, 65'd0);
            tick();
        end
        check({tag, " valid"}, {64'd0, out_valid}, 65'd1);
        check({tag, " sum"}, sout, exp);
        tick();
        check({tag, " valid drop"}, {64'd0, out_valid}, 65'd0);
        check({tag, " sum hold"}, sout, exp);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        tick();
        tick();
        check("reset sout", sout, 65'd0);
        check("reset valid", {64'd0, out_valid}, 65'd0);
        rst = 1'b0;
        tick();
        check("idle valid", {64'd0, out_valid}, 65'd0);

        single_op("small", 64'd5, 64'd7, 65'd12);
        single_op("max-1 + 1", 64'd18446744073709551614, 64'd1, 65'h0_FFFF_FFFF_FFFF_FFFF);
        single_op("large pair", 64'd8446744073709551614, 64'd10000000000000000000,
                  65'h0_FFFF_FFFF_FFFF_FFFE);
        single_op("slice0 carry", 64'h0000_0000_0000_FFFF, 64'd1, 65'h0_0000_0000_0001_0000);
        single_op("all ones + 1", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 65'h1_0000_0000_0000_0000);
        single_op("all ones x2", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                  65'h1_FFFF_FFFF_FFFF_FFFE);

        // Back-to-back operations, one per cycle
        in_valid = 1'b1;
        a = 64'd184;       b = 64'd1256;   tick();
        a = 64'd14;        b = 64'd7;      tick();
        a = 64'd156596564; b = 64'd125556; tick();
        in_valid = 1'b0;
        a = 'x;
        b = 'x;
        tick();
        check("b2b 1 valid", {64'd0, out_valid}, 65'd1);
        check("b2b 1 sum", sout, 65'd1440);
        tick();
        check("b2b 2 valid", {64'd0, out_valid}, 65'd1);
        check("b2b 2 sum", sout, 65'd21);
        tick();
        check("b2b 3 valid", {64'd0, out_valid}, 65'd1);
        check("b2b 3 sum", sout, 65'd156722120);
        tick();
        check("b2b end valid", {64'd0, out_valid}, 65'd0);
        check("b2b end hold", sout, 65'd156722120);

        // Reset with three operations in flight and a fourth offered at the reset edge
        in_valid = 1'b1;
        a = 64'd100; b = 64'd1; tick();
        a = 64'd200; b = 64'd2; tick();
        a = 64'd300; b = 64'd3; tick();
        rst = 1'b1;
        a = 64'd400; b = 64'd4;
        tick();
        check("flush valid", {64'd0, out_valid}, 65'd0);
        check("flush sout", sout, 65'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post flush valid", {64'd0, out_valid}, 65'd0);
            check("post flush sout", sout, 65'd0);
        end

        // Random operands with random gaps against a cycle-level reference pipeline
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_v[i] = 1'b0;
            m_s[i] = '0;
        end
        verbose = 1'b0;
        for (int n = 0; n < 10000; n++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            a        = {$urandom, $urandom};
            b        = {$urandom, $urandom};
            if (n % 97 == 0) begin
                a = 64'hFFFF_FFFF_FFFF_FFFF;
            end
            tick();
            for (int i = 3; i > 0; i--) begin
                if (m_v[i-1]) m_s[i] = m_s[i-1];
                m_v[i] = m_v[i-1];
            end
            if (in_valid) m_s[0] = {1'b0, a} + {1'b0, b};
            m_v[0] = in_valid;
            check("random valid", {64'd0, out_valid}, {64'd0, m_v[3]});
            check("random sum", sout, m_s[3]);
        end
        verbose = 1'b1;
        $display("random run: 10000 cycles compared");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
